tnn_feature_sequencer: RTL and testbench

Streaming front/back end for the combinational approximate TNN classifiers (5 features × 3 bit → 1-bit class). It accepts features one per beat over a valid/ready stream, assembles them into a vector, holds that vector stable on the classifier input bus, samples the classifier's decision, and returns it on an output valid/ready stream with a frame index. It sits between the dataset/feature DMA and any interchangeable classifier netlist from the approximate-circuit library.

---
 rtl/tnn_pkg.sv | 21 ++
 rtl/tnn_vec_assembler.sv | 46 ++++
 rtl/tnn_feature_sequencer.sv | 122 ++++++++++++
 tb/tb_tnn_feature_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// Shared types and constants for the TNN feature sequencer and its vector assembler.
// Optional statistics are enabled in the sequencer by defining TNN_SEQ_STATS_EN.
package tnn_pkg;

   localparam int TNN_FEAT_W = 3;
   localparam int TNN_N_FEAT = 5;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      EVAL    = 2'd1,
      HOLD    = 2'd2
   } tnn_seq_state_t;

   typedef logic [TNN_N_FEAT*TNN_FEAT_W-1:0] tnn_vec_t;

   // Width of a pointer that can address n slots (at least one bit).
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tnn_vec_assembler.sv
// Collects features into slot registers (slot a at the LSBs) and flags framing errors:
// s_last before the final slot, or a final slot arriving without s_last.
module tnn_vec_assembler
   import tnn_pkg::*;
#(
   parameter int FEAT_W = TNN_FEAT_W,
   parameter int N_FEAT = TNN_N_FEAT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_beat,
   input  logic [FEAT_W-1:0]          i_data,
   input  logic                       i_last,
   output logic [N_FEAT*FEAT_W-1:0]   o_vec,
   output logic                       o_frame_done,
   output logic                       o_err_event
);

   localparam int                PTR_W     = ptr_width(N_FEAT);
   localparam logic [PTR_W-1:0]  LAST_SLOT = PTR_W'(N_FEAT - 1);

   logic [PTR_W-1:0]          r_ptr;
   logic [N_FEAT*FEAT_W-1:0]  r_vec;
   logic                      w_at_last;

   assign w_at_last    = (r_ptr == LAST_SLOT);
   assign o_frame_done = i_beat & w_at_last;
   // Early s_last drops the partial frame; a missing s_last still completes it.
   assign o_err_event  = i_beat & (w_at_last ? ~i_last : i_last);
   assign o_vec        = r_vec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
         r_vec <= '0;
      end else if (i_beat) begin
         r_vec[r_ptr*FEAT_W +: FEAT_W] <= i_data;
         if (w_at_last || i_last) begin
            r_ptr <= '0;
         end else begin
            r_ptr <= r_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tnn_feature_sequencer.sv
// Streams features into a held classifier vector, samples the decision and returns it
// with a frame index. Define TNN_SEQ_STATS_EN to add the saturating pos_cnt counter.
module tnn_feature_sequencer
   import tnn_pkg::*;
#(
   parameter int FEAT_W = TNN_FEAT_W,
   parameter int N_FEAT = TNN_N_FEAT,
   parameter int IDX_W  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [FEAT_W-1:0]          s_data,
   input  logic                       s_last,
   output logic [N_FEAT*FEAT_W-1:0]   feat_vec,
   input  logic                       cls_in,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic                       m_class,
   output logic [IDX_W-1:0]           m_index,
   input  logic                       clr_err,
   output logic                       err_sticky,
`ifdef TNN_SEQ_STATS_EN
   output logic [CNT_W-1:0]           pos_cnt,
`endif
   output logic [1:0]                 o_dbg_state
);

   // Both streams: a transfer happens on a rising edge where valid & ready are high;
   // s_ready and m_valid come from the state register only, never from m_ready.

   tnn_seq_state_t    r_state;
   tnn_seq_state_t    w_next_state;
   logic              r_m_class;
   logic [IDX_W-1:0]  r_m_index;
   logic [IDX_W-1:0]  r_frame_idx;
   logic              r_err_sticky;
   logic              w_beat;
   logic              w_frame_done;
   logic              w_err_event;

   assign s_ready     = rst_n & (r_state == COLLECT);
   assign m_valid     = (r_state == HOLD);
   assign m_class     = r_m_class;
   assign m_index     = r_m_index;
   assign err_sticky  = r_err_sticky;
   assign o_dbg_state = r_state;
   assign w_beat      = s_valid & s_ready;

   tnn_vec_assembler #(
      .FEAT_W (FEAT_W),
      .N_FEAT (N_FEAT)
   ) u_assembler (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_beat       (w_beat),
      .i_data       (s_data),
      .i_last       (s_last),
      .o_vec        (feat_vec),
      .o_frame_done (w_frame_done),
      .o_err_event  (w_err_event)
   );

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         COLLECT: if (w_frame_done) w_next_state = EVAL;
         EVAL:    w_next_state = HOLD;
         HOLD:    if (m_ready) w_next_state = COLLECT;
         default: w_next_state = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= COLLECT;
         r_m_class   <= 1'b0;
         r_m_index   <= '0;
         r_frame_idx <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == EVAL) begin
            r_m_class   <= cls_in;
            r_m_index   <= r_frame_idx;
            r_frame_idx <= r_frame_idx + 1'b1;
         end
      end
   end

   // A new framing error in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_sticky <= 1'b0;
      end else if (w_err_event) begin
         r_err_sticky <= 1'b1;
      end else if (clr_err) begin
         r_err_sticky <= 1'b0;
      end
   end

`ifdef TNN_SEQ_STATS_EN
   logic [CNT_W-1:0]  r_pos_cnt;
   logic              w_pos_inc;

   assign w_pos_inc = (r_state == EVAL) & cls_in;
   assign pos_cnt   = r_pos_cnt;

   // Clearing restarts from the decision made in the same cycle, if any.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pos_cnt <= '0;
      end else if (clr_err) begin
         r_pos_cnt <= CNT_W'(w_pos_inc);
      end else if (w_pos_inc && (r_pos_cnt != {CNT_W{1'b1}})) begin
         r_pos_cnt <= r_pos_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_tnn_feature_sequencer.sv
// Directed bench for tnn_feature_sequencer with an (a > b) classifier model.
// Define TNN_SEQ_STATS_EN to also exercise the saturating pos_cnt counter.
module tb_tnn_feature_sequencer;
   import tnn_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [2:0]   s_data = 3'd0;
   logic         s_last = 1'b0;
   logic [14:0]  feat_vec;
   logic         cls_in;
   logic         m_valid;
   logic         m_ready = 1'b0;
   logic         m_class;
   logic [7:0]   m_index;
   logic         clr_err = 1'b0;
   logic         err_sticky;
   logic [1:0]   o_dbg_state;
`ifdef TNN_SEQ_STATS_EN
   logic [1:0]   pos_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [14:0]  exp_vec_12345;
   logic [2:0]   fa;
   logic [2:0]   fb;
   logic         exp_cls;

   tnn_feature_sequencer #(
      .FEAT_W (3),
      .N_FEAT (5),
      .IDX_W  (8),
      .CNT_W  (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .feat_vec    (feat_vec),
      .cls_in      (cls_in),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_class     (m_class),
      .m_index     (m_index),
      .clr_err     (clr_err),
      .err_sticky  (err_sticky),
`ifdef TNN_SEQ_STATS_EN
      .pos_cnt     (pos_cnt),
`endif
      .o_dbg_state (o_dbg_state)
   );

   // Classifier stand-in: decision is (a > b).
   assign cls_in = (feat_vec[2:0] > feat_vec[5:3]);

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [2:0] d, input logic l);
      int t = 0;
      while (!s_ready && t < 20) begin
         step();
         t++;
      end
      if (!s_ready) chk("s_ready_timeout", {31'b0, s_ready}, 32'd1);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_frame(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                             input logic [2:0] d, input logic [2:0] e, input logic last_ok);
      send_beat(a, 1'b0);
      send_beat(b, 1'b0);
      send_beat(c, 1'b0);
      send_beat(d, 1'b0);
      send_beat(e, last_ok);
   endtask

   task automatic wait_result();
      int t = 0;
      while (!m_valid && t < 10) begin
         step();
         t++;
      end
      chk("result_wait", {31'b0, m_valid}, 32'd1);
   endtask

   initial begin
      exp_vec_12345 = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1};

      // Reset
      #12;
      chk("rst_feat_vec", {17'b0, feat_vec}, 32'd0);
      chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
      chk("rst_s_ready", {31'b0, s_ready}, 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      chk("idle_s_ready", {31'b0, s_ready}, 32'd1);
      chk("idle_m_class", {31'b0, m_class}, 32'd0);
      chk("idle_m_index", {24'b0, m_index}, 32'd0);
      chk("idle_err", {31'b0, err_sticky}, 32'd0);
      chk("idle_state", {30'b0, o_dbg_state}, 32'(COLLECT));

      // Early s_last on the third beat drops the frame
      send_beat(3'd7, 1'b0);
      send_beat(3'd6, 1'b0);
      send_beat(3'd5, 1'b1);
      chk("early_err", {31'b0, err_sticky}, 32'd1);
      chk("early_s_ready", {31'b0, s_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         chk("early_no_valid", {31'b0, m_valid}, 32'd0);
         step();
      end
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("clr_err", {31'b0, err_sticky}, 32'd0);

      // Nominal frame with m_ready high
      m_ready = 1'b1;
      send_frame(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 1'b1);
      chk("nom_feat_vec", {17'b0, feat_vec}, {17'b0, exp_vec_12345});
      chk("nom_eval_state", {30'b0, o_dbg_state}, 32'(EVAL));
      chk("nom_eval_no_valid", {31'b0, m_valid}, 32'd0);
      chk("nom_eval_s_ready", {31'b0, s_ready}, 32'd0);
      step();
      chk("nom_valid", {31'b0, m_valid}, 32'd1);
      chk("nom_class", {31'b0, m_class}, 32'd0);
      chk("nom_index", {24'b0, m_index}, 32'd0);
      chk("nom_err", {31'b0, err_sticky}, 32'd0);
      step();
      chk("nom_valid_drop", {31'b0, m_valid}, 32'd0);
      chk("nom_s_ready_back", {31'b0, s_ready}, 32'd1);

      // Backpressure: 10 cycles of m_ready low
      m_ready = 1'b0;
      send_frame(3'd6, 3'd3, 3'd0, 3'd1, 3'd2, 1'b1);
      step();
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", {31'b0, m_valid}, 32'd1);
         chk("bp_class", {31'b0, m_class}, 32'd1);
         chk("bp_index", {24'b0, m_index}, 32'd1);
         chk("bp_s_ready", {31'b0, s_ready}, 32'd0);
         step();
      end
      m_ready = 1'b1;
      step();
      chk("bp_valid_drop", {31'b0, m_valid}, 32'd0);
      chk("bp_s_ready_back", {31'b0, s_ready}, 32'd1);

      // Missing s_last, with clr_err in the same cycle as the error (set wins)
      send_beat(3'd7, 1'b0);
      send_beat(3'd0, 1'b0);
      send_beat(3'd1, 1'b0);
      send_beat(3'd2, 1'b0);
      clr_err = 1'b1;
      send_beat(3'd3, 1'b0);
      clr_err = 1'b0;
      chk("miss_err", {31'b0, err_sticky}, 32'd1);
      wait_result();
      chk("miss_class", {31'b0, m_class}, 32'd1);
      chk("miss_index", {24'b0, m_index}, 32'd2);

      // Index runs up through 255 and wraps to 0
      for (int k = 3; k <= 256; k++) begin
         fa = 3'(k % 8);
         fb = 3'((k / 8) % 8);
         exp_cls = (fa > fb);
         send_frame(fa, fb, 3'd2, 3'd5, 3'd6, 1'b1);
         wait_result();
         chk("wrap_index", {24'b0, m_index}, 32'(k % 256));
         chk("wrap_class", {31'b0, m_class}, {31'b0, exp_cls});
      end

      // Asynchronous reset mid-frame
      step();
      send_beat(3'd7, 1'b0);
      send_beat(3'd7, 1'b0);
      send_beat(3'd7, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_feat_vec", {17'b0, feat_vec}, 32'd0);
      chk("mrst_err", {31'b0, err_sticky}, 32'd0);
      chk("mrst_m_valid", {31'b0, m_valid}, 32'd0);
      chk("mrst_m_index", {24'b0, m_index}, 32'd0);
      chk("mrst_s_ready", {31'b0, s_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_frame(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 1'b1);
      chk("post_rst_feat_vec", {17'b0, feat_vec}, {17'b0, exp_vec_12345});
      wait_result();
      chk("post_rst_index", {24'b0, m_index}, 32'd0);
      chk("post_rst_err", {31'b0, err_sticky}, 32'd0);

`ifdef TNN_SEQ_STATS_EN
      // Five positive decisions saturate a 2-bit counter at 3
      for (int k = 0; k < 5; k++) begin
         send_frame(3'd5, 3'd1, 3'd0, 3'd0, 3'd0, 1'b1);
         wait_result();
      end
      step();
      chk("stats_saturate", {30'b0, pos_cnt}, 32'd3);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("stats_clear", {30'b0, pos_cnt}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
